add_pipe: RTL and testbench

//   Parametrised, pipelined WIDTH-bit adder/subtractor built as a chain of

---
 rtl/add_pipe.sv | 174 +++++++++++++++++
 tb/tb_add_pipe.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/add_pipe.sv
// ---------------------------------------------------------------------------
// add_pipe -- pipelined WIDTH-bit adder/subtractor with valid/ready handshake
//
// The operation is split into STAGES chunk adders of CW = WIDTH/STAGES bits.
// Each chunk adder uses the plain full-adder sum/carry equations. The carry
// between chunks is registered, so one new operand pair can enter per cycle.
// A result appears STAGES cycles after it is accepted.
//
// Parameters
//   WIDTH   operand/sum width in bits (must be a multiple of STAGES)
//   STAGES  pipeline depth = number of chunks
//
// Ports
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair present
//   in_ready   block can accept operands this cycle (low only on stall)
//   a, b       operands
//   c_in       carry-in (add) / borrow-in (sub)
//   sub        0: a+b+c_in   1: a-b-c_in
//   out_valid  result present
//   out_ready  consumer accepts result
//   sum        result modulo 2^WIDTH
//   c_out      raw carry out of the MSB (sub mode: 1 = no borrow)
//   ovf        two's-complement signed overflow
//
// Datapath layout
//   Each stage carries one WIDTH-bit "accumulator" word. The word enters as A.
//   Every stage adds its low chunk to the low chunk of the remaining B' bits.
//   It then shifts the word right by one chunk and drops the new sum chunk in
//   at the top. After STAGES stages, the word holds the aligned sum. No
//   separate deskew registers are needed, and every stored bit is used.
//   The remaining B' bits shrink by one chunk per stage.
// ---------------------------------------------------------------------------
module add_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  // Effective operands: subtraction is a + ~b + ~borrow.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // vld_pipe[0] is the incoming valid. vld_pipe[k] is the registered valid
  // of stage k-1's output register. vld_pipe[STAGES] is out_valid.
  logic [STAGES:1]  vld_q;
  logic [STAGES:0]  vld_pipe;
  logic             stall;
  logic             adv;

  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             ovf_q;

  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = sub ? ~c_in : c_in;

  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[STAGES];

  // One global enable. A stalled output freezes the whole pipe, so no
  // bubble is inserted and nothing is overwritten. If the output is free,
  // everything advances, even when a new item arrives in the same cycle
  // as an item leaves.
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= vld_pipe[STAGES-1:0];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    // Number of B' bits still pending when this stage is entered.
    localparam int RW = (STAGES - s) * CW;

    logic [WIDTH-1:0] acc_in;
    logic [RW-1:0]    b_in;
    logic             cy_in;
    logic [CW-1:0]    s_chunk;
    logic             co;
    logic [WIDTH-1:0] acc_d;

    if (s == 0) begin : g_src
      assign acc_in = a;
      assign b_in   = b_eff;
      assign cy_in  = cin_eff;
    end else begin : g_src
      assign acc_in = g_stg[s-1].g_mid.acc_q;
      assign b_in   = g_stg[s-1].g_mid.b_q;
      assign cy_in  = g_stg[s-1].g_mid.c_q;
    end

    // Ripple chunk adder built from full-adder cells.
    always_comb begin : p_chunk
      logic c;
      s_chunk = '0;
      c       = cy_in;
      for (int i = 0; i < CW; i++) begin
        s_chunk[i] = acc_in[i] ^ b_in[i] ^ c;
        c          = (acc_in[i] & b_in[i]) | (c & (acc_in[i] ^ b_in[i]));
      end
      co = c;
    end

    // Consume the low chunk and park the new sum chunk at the top.
    if (CW == WIDTH) begin : g_nx
      assign acc_d = s_chunk;
    end else begin : g_nx
      assign acc_d = {s_chunk, acc_in[WIDTH-1:CW]};
    end

    if (s < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0]  acc_q;
      logic [RW-CW-1:0]  b_q;
      logic              c_q;

      // Data registers advance with the pipe. Their contents in an empty
      // slot do not matter.
      always_ff @(posedge clk) begin
        if (rst) begin
          acc_q <= '0;
          b_q   <= '0;
          c_q   <= 1'b0;
        end else if (adv) begin
          acc_q <= acc_d;
          b_q   <= b_in[RW-1:CW];
          c_q   <= co;
        end
      end
    end else begin : g_last
      // Output registers load only for a real item, so a bubble leaves the
      // last result visible. The top chunk holds the operand MSBs:
      // carry-into-MSB = a^b'^sum at that bit, and overflow is that carry
      // XOR carry-out.
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q   <= '0;
          c_out_q <= 1'b0;
          ovf_q   <= 1'b0;
        end else if (adv && vld_pipe[s]) begin
          sum_q   <= acc_d;
          c_out_q <= co;
          ovf_q   <= acc_in[CW-1] ^ b_in[CW-1] ^ s_chunk[CW-1] ^ co;
        end
      end
    end
  end

endmodule

// File: tb/tb_add_pipe.sv
module tb_add_pipe;
  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
  logic [W-1:0] a, b, sum;

  add_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         ovf;
    logic         c;
    logic [W-1:0] s;
  } res_t;

  // Reference: results queued in acceptance order, plus the occupancy of a
  // depth-S conveyor that freezes while the head result is refused.
  res_t         expq[$];
  logic [S-1:0] mv;
  res_t         last;
  int           nchk = 0, nfail = 0, nout = 0;
  int           sent, guard, nout0, cnt;
  res_t         r1;

  function automatic res_t ref_op(input logic [W-1:0] ra, rb, input logic rc, rs);
    logic [W-1:0] bp;
    logic         ci;
    logic [W:0]   t;
    res_t         r;
    bp    = rs ? ~rb : rb;
    ci    = rs ? ~rc : rc;
    t     = {1'b0, ra} + {1'b0, bp} + {{W{1'b0}}, ci};
    r.s   = t[W-1:0];
    r.c   = t[W];
    r.ovf = (ra[W-1] == bp[W-1]) && (t[W-1] != ra[W-1]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check in_ready, take the edge, then
  // check outputs at the next negedge.
  task automatic cyc(input logic r, iv, input logic [W-1:0] ia, ib,
                     input logic ic, isub, ordy);
    logic stall_m;
    rst = r; in_valid = iv; a = ia; b = ib; c_in = ic; sub = isub; out_ready = ordy;
    #1;
    stall_m = mv[S-1] && !ordy;
    check("in_ready", {31'b0, in_ready}, {31'b0, !stall_m});
    @(posedge clk);
    if (r) begin
      mv = '0;
      expq.delete();
      last = '0;
    end else if (!stall_m) begin
      if (mv[S-1]) begin
        void'(expq.pop_front());
        nout++;
      end
      mv = {mv[S-2:0], iv};
      if (iv) expq.push_back(ref_op(ia, ib, ic, isub));
    end
    if (mv[S-1]) last = expq[0];
    @(negedge clk);
    check("out_valid", {31'b0, out_valid}, {31'b0, mv[S-1]});
    check("sum",       {16'b0, sum},       {16'b0, last.s});
    check("c_out",     {31'b0, c_out},     {31'b0, last.c});
    check("ovf",       {31'b0, ovf},       {31'b0, last.ovf});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    mv = '0; last = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_sum",       {16'b0, sum},       32'd0);
    check("rst_c_out",     {31'b0, c_out},     32'd0);
    check("rst_ovf",       {31'b0, ovf},       32'd0);
    @(negedge clk);

    // Directed cases: accept, then 3 idle cycles, so the result appears 4 cycles later.
    cyc(1'b0, 1'b1, 16'h1234, 16'h0001, 1'b0, 1'b0, 1'b1); idle(3);
    check("t1_valid", {31'b0, out_valid}, 32'd1);
    check("t1_sum",   {16'b0, sum},       32'h1235);
    check("t1_cout",  {31'b0, c_out},     32'd0);
    check("t1_ovf",   {31'b0, ovf},       32'd0);

    cyc(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1); idle(3);
    check("t2_sum",  {16'b0, sum},   32'h0000);
    check("t2_cout", {31'b0, c_out}, 32'd1);
    check("t2_ovf",  {31'b0, ovf},   32'd0);

    cyc(1'b0, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1); idle(3);
    check("t3a_sum", {16'b0, sum}, 32'h8000);
    check("t3a_ovf", {31'b0, ovf}, 32'd1);

    cyc(1'b0, 1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1); idle(3);
    check("t3b_sum",  {16'b0, sum},   32'hFFFE);
    check("t3b_cout", {31'b0, c_out}, 32'd0);
    check("t3b_ovf",  {31'b0, ovf},   32'd0);
    idle(2);

    // Random back-to-back stream with random back-pressure.
    nout0 = nout; sent = 0; guard = 0;
    while (sent < 32 && guard < 400) begin
      logic ordy;
      ordy = 1'($urandom);
      if (!(mv[S-1] && !ordy)) sent++;
      cyc(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), ordy);
      guard++;
    end
    check("t4_sent", sent, 32);
    guard = 0;
    while (expq.size() > 0 && guard < 20) begin
      idle(1);
      guard++;
    end
    check("t4_drained", expq.size(), 0);
    check("t4_count", nout - nout0, 32);

    // Fill with 4 items, refuse the output for 10 cycles, then release.
    r1 = ref_op(16'hA5A5, 16'h1111, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 16'hA5A5, 16'h1111, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0);
      check("t5_hold_sum", {16'b0, sum}, {16'b0, r1.s});
    end
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) cnt++;
      idle(1);
    end
    check("t5_consec", cnt, 4);
    check("t5_empty", {31'b0, out_valid}, 32'd0);

    // Reset with 3 items in flight. Those items must never appear.
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    cyc(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    check("t6_valid", {31'b0, out_valid}, 32'd0);
    check("t6_sum",   {16'b0, sum},       32'd0);
    cyc(1'b0, 1'b1, 16'h00FF, 16'h0100, 1'b1, 1'b0, 1'b1); idle(3);
    check("t6_new_valid", {31'b0, out_valid}, 32'd1);
    check("t6_new_sum",   {16'b0, sum},       32'h0200);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
